// File: rtl/mips_multicycle_control_if.sv
// Control/datapath bundle between the multi-cycle MIPS control FSM and the shared-memory datapath.
// The control unit sits on the master side; the datapath and memory sit on the slave side.
interface mips_multicycle_control_if #(
    parameter int ALUOP_WIDTH = 3,
    parameter int CNT_WIDTH   = 32
) ();
    logic [5:0]             OP;
    logic                   Zero;
    logic                   MemReady;
    logic                   PCWrite;
    logic                   IorD;
    logic                   MemRead;
    logic                   MemWrite;
    logic                   IRWrite;
    logic                   RegDst;
    logic                   MemtoReg;
    logic                   RegWrite;
    logic                   ALUSrcA;
    logic [1:0]             ALUSrcB;
    logic [1:0]             PCSource;
    logic [ALUOP_WIDTH-1:0] ALUOp;
    logic                   IllegalOp;
    logic                   InstrDone;
    logic [CNT_WIDTH-1:0]   RetiredCnt;

    modport master (
        input  OP, Zero, MemReady,
        output PCWrite, IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
               ALUSrcA, ALUSrcB, PCSource, ALUOp, IllegalOp, InstrDone, RetiredCnt
    );

    modport slave (
        output OP, Zero, MemReady,
        input  PCWrite, IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
               ALUSrcA, ALUSrcB, PCSource, ALUOp, IllegalOp, InstrDone, RetiredCnt
    );
endinterface

// File: rtl/mips_multicycle_control.sv
// Multi-cycle MIPS control FSM: sequences fetch/decode/execute/memory/writeback over a shared
// memory, stalls on MemReady, and counts retired instructions.
module mips_multicycle_control #(
    parameter int ALUOP_WIDTH = 3,
    parameter int CNT_WIDTH   = 32,
    parameter int MEM_WAIT    = 1
) (
    input  logic clk,
    input  logic reset,
    mips_multicycle_control_if.master bus
);

    localparam logic [5:0] OP_R    = 6'h00;
    localparam logic [5:0] OP_J    = 6'h02;
    localparam logic [5:0] OP_BEQ  = 6'h04;
    localparam logic [5:0] OP_BNE  = 6'h05;
    localparam logic [5:0] OP_ADDI = 6'h08;
    localparam logic [5:0] OP_ANDI = 6'h0C;
    localparam logic [5:0] OP_ORI  = 6'h0D;
    localparam logic [5:0] OP_LUI  = 6'h0F;
    localparam logic [5:0] OP_LW   = 6'h23;
    localparam logic [5:0] OP_SW   = 6'h2B;

    localparam logic [2:0] ALU_ADD   = 3'b100;
    localparam logic [2:0] ALU_SUB   = 3'b001;
    localparam logic [2:0] ALU_FUNCT = 3'b111;
    localparam logic [2:0] ALU_OR    = 3'b101;
    localparam logic [2:0] ALU_AND   = 3'b110;
    localparam logic [2:0] ALU_LUI   = 3'b000;

    typedef enum logic [3:0] {
        IDLE, FETCH, DECODE, R_EXEC, R_WB, I_EXEC, I_WB,
        MEM_ADDR, MEM_READ, MEM_WB, MEM_WRITE, BRANCH, JUMP
    } state_t;

    typedef struct packed {
        logic       pc_write;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] pc_source;
        logic [2:0] alu_op;
        logic       retire;
    } ctrl_t;

    state_t               state;
    state_t               next_state;
    logic [5:0]           op_q;
    logic [5:0]           op_next;
    ctrl_t                ctrl;
    logic [CNT_WIDTH-1:0] retired_cnt;
    logic                 ready;
    logic                 instr_done;
    logic                 branch_taken;
    logic [ALUOP_WIDTH-1:0] alu_op_full;

    function automatic logic is_legal(input logic [5:0] op);
        case (op)
            OP_R, OP_J, OP_BEQ, OP_BNE, OP_ADDI, OP_ANDI, OP_ORI, OP_LUI, OP_LW, OP_SW:
                is_legal = 1'b1;
            default:
                is_legal = 1'b0;
        endcase
    endfunction

    // Moore control bits for the state being entered; op is the opcode that state will see
    function automatic ctrl_t decode_ctrl(input state_t s, input logic [5:0] op);
        ctrl_t c;
        c = '0;
        case (s)
            FETCH: begin
                c.mem_read  = 1'b1;
                c.alu_src_b = 2'b01;
                c.alu_op    = ALU_ADD;
            end
            DECODE: begin
                c.alu_src_b = 2'b11;
                c.alu_op    = ALU_ADD;
            end
            R_EXEC: begin
                c.alu_src_a = 1'b1;
                c.alu_op    = ALU_FUNCT;
            end
            R_WB: begin
                c.reg_dst   = 1'b1;
                c.reg_write = 1'b1;
                c.retire    = 1'b1;
            end
            I_EXEC: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = 2'b10;
                case (op)
                    OP_ORI:  c.alu_op = ALU_OR;
                    OP_ANDI: c.alu_op = ALU_AND;
                    OP_LUI:  c.alu_op = ALU_LUI;
                    default: c.alu_op = ALU_ADD;
                endcase
            end
            I_WB: begin
                c.reg_write = 1'b1;
                c.retire    = 1'b1;
            end
            MEM_ADDR: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = 2'b10;
                c.alu_op    = ALU_ADD;
            end
            MEM_READ: begin
                c.mem_read = 1'b1;
                c.iord     = 1'b1;
            end
            MEM_WB: begin
                c.mem_to_reg = 1'b1;
                c.reg_write  = 1'b1;
                c.retire     = 1'b1;
            end
            MEM_WRITE: begin
                c.mem_write = 1'b1;
                c.iord      = 1'b1;
            end
            BRANCH: begin
                c.alu_src_a = 1'b1;
                c.alu_op    = ALU_SUB;
                c.pc_source = 2'b01;
                c.retire    = 1'b1;
            end
            JUMP: begin
                c.pc_source = 2'b10;
                c.pc_write  = 1'b1;
                c.retire    = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

    assign ready   = (MEM_WAIT != 0) ? bus.MemReady : 1'b1;
    assign op_next = (state == DECODE) ? bus.OP : op_q;

    always_comb begin
        next_state = state;
        case (state)
            IDLE:     next_state = FETCH;
            FETCH:    next_state = ready ? DECODE : FETCH;
            DECODE: begin
                case (bus.OP)
                    OP_R:                            next_state = R_EXEC;
                    OP_ADDI, OP_ORI, OP_ANDI, OP_LUI: next_state = I_EXEC;
                    OP_LW, OP_SW:                    next_state = MEM_ADDR;
                    OP_BEQ, OP_BNE:                  next_state = BRANCH;
                    OP_J:                            next_state = JUMP;
                    default:                         next_state = FETCH;
                endcase
            end
            R_EXEC:    next_state = R_WB;
            I_EXEC:    next_state = I_WB;
            MEM_ADDR:  next_state = (op_q == OP_LW) ? MEM_READ : MEM_WRITE;
            MEM_READ:  next_state = ready ? MEM_WB : MEM_READ;
            MEM_WRITE: next_state = ready ? FETCH : MEM_WRITE;
            default:   next_state = FETCH;
        endcase
    end

    // A store only retires on the cycle its memory access actually completes
    assign instr_done   = ctrl.retire | ((state == MEM_WRITE) & ready);
    assign branch_taken = (op_q == OP_BEQ) ? bus.Zero : ~bus.Zero;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            op_q        <= '0;
            ctrl        <= '0;
            retired_cnt <= '0;
        end else begin
            state <= next_state;
            op_q  <= op_next;
            ctrl  <= decode_ctrl(next_state, op_next);
            if (instr_done) begin
                retired_cnt <= retired_cnt + CNT_WIDTH'(1);
            end
        end
    end

    always_comb begin
        alu_op_full      = '0;
        alu_op_full[2:0] = ctrl.alu_op;
    end

    assign bus.PCWrite    = ctrl.pc_write
                          | ((state == FETCH) & ready)
                          | ((state == BRANCH) & branch_taken);
    assign bus.IRWrite    = (state == FETCH) & ready;
    assign bus.IorD       = ctrl.iord;
    assign bus.MemRead    = ctrl.mem_read;
    assign bus.MemWrite   = ctrl.mem_write;
    assign bus.RegDst     = ctrl.reg_dst;
    assign bus.MemtoReg   = ctrl.mem_to_reg;
    assign bus.RegWrite   = ctrl.reg_write;
    assign bus.ALUSrcA    = ctrl.alu_src_a;
    assign bus.ALUSrcB    = ctrl.alu_src_b;
    assign bus.PCSource   = ctrl.pc_source;
    assign bus.ALUOp      = alu_op_full;
    assign bus.IllegalOp  = (state == DECODE) & ~is_legal(bus.OP);
    assign bus.InstrDone  = instr_done;
    assign bus.RetiredCnt = retired_cnt;

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Self-checking bench for mips_multicycle_control: per-cycle control vectors against a spec-derived
// phase table, plus a scoreboard of per-instruction latency and retired count.
module tb_mips_multicycle_control;

    logic clk = 1'b0;
    logic reset = 1'b0;

    always #5 clk = ~clk;

    mips_multicycle_control_if #(.ALUOP_WIDTH(4), .CNT_WIDTH(4))  bus ();
    mips_multicycle_control_if #(.ALUOP_WIDTH(3), .CNT_WIDTH(32)) bus_nowait ();

    mips_multicycle_control #(.ALUOP_WIDTH(4), .CNT_WIDTH(4), .MEM_WAIT(1)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    mips_multicycle_control #(.ALUOP_WIDTH(3), .CNT_WIDTH(32), .MEM_WAIT(0)) dut_nowait (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_nowait)
    );

    typedef enum {
        P_IDLE, P_FETCH, P_DECODE, P_R_EXEC, P_R_WB, P_I_EXEC, P_I_WB,
        P_MEM_ADDR, P_MEM_READ, P_MEM_WB, P_MEM_WRITE, P_BRANCH, P_JUMP
    } phase_t;

    typedef struct {
        string      name;
        int         cycles;
        logic [3:0] cnt;
    } sb_entry_t;

    typedef struct {
        string      name;
        logic [5:0] op;
        logic       zero;
        int         fetch_stalls;
        int         mem_stalls;
    } instr_t;

    sb_entry_t  scoreboard[$];
    int         num_checks = 0;
    int         num_errors = 0;
    logic [3:0] model_cnt  = 4'd0;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        num_checks++;
        if (actual !== expected) begin
            num_errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    function automatic bit is_legal(input logic [5:0] op);
        return op inside {6'h00, 6'h02, 6'h04, 6'h05, 6'h08, 6'h0C, 6'h0D, 6'h0F, 6'h23, 6'h2B};
    endfunction

    // Packing: {PCWrite,IorD,MemRead,MemWrite,IRWrite,RegDst,MemtoReg,RegWrite,ALUSrcA,ALUSrcB,PCSource,ALUOp,IllegalOp,InstrDone}
    function automatic logic [18:0] observed_outputs();
        return {bus.PCWrite, bus.IorD, bus.MemRead, bus.MemWrite, bus.IRWrite, bus.RegDst,
                bus.MemtoReg, bus.RegWrite, bus.ALUSrcA, bus.ALUSrcB, bus.PCSource, bus.ALUOp,
                bus.IllegalOp, bus.InstrDone};
    endfunction

    function automatic logic [18:0] expect_outputs(input phase_t p, input logic [5:0] op,
                                                   input logic zero, input logic ready);
        logic       pcw, iord, mr, mw, irw, rdst, m2r, rw, srca, ill, done;
        logic [1:0] srcb, pcsrc;
        logic [3:0] aluop;
        {pcw, iord, mr, mw, irw, rdst, m2r, rw, srca, ill, done} = '0;
        srcb  = 2'b00;
        pcsrc = 2'b00;
        aluop = 4'b0000;
        case (p)
            P_FETCH:     begin mr = 1; srcb = 2'b01; aluop = 4'b0100; irw = ready; pcw = ready; end
            P_DECODE:    begin srcb = 2'b11; aluop = 4'b0100; ill = !is_legal(op); end
            P_R_EXEC:    begin srca = 1; srcb = 2'b00; aluop = 4'b0111; end
            P_R_WB:      begin rdst = 1; rw = 1; done = 1; end
            P_I_EXEC: begin
                srca = 1;
                srcb = 2'b10;
                aluop = (op == 6'h08) ? 4'b0100 : (op == 6'h0D) ? 4'b0101 :
                        (op == 6'h0C) ? 4'b0110 : 4'b0000;
            end
            P_I_WB:      begin rw = 1; done = 1; end
            P_MEM_ADDR:  begin srca = 1; srcb = 2'b10; aluop = 4'b0100; end
            P_MEM_READ:  begin mr = 1; iord = 1; end
            P_MEM_WB:    begin m2r = 1; rw = 1; done = 1; end
            P_MEM_WRITE: begin mw = 1; iord = 1; done = ready; end
            P_BRANCH: begin
                srca = 1; aluop = 4'b0001; pcsrc = 2'b01; done = 1;
                pcw = (op == 6'h04) ? zero : !zero;
            end
            P_JUMP:      begin pcsrc = 2'b10; pcw = 1; done = 1; end
            default: ;
        endcase
        return {pcw, iord, mr, mw, irw, rdst, m2r, rw, srca, srcb, pcsrc, aluop, ill, done};
    endfunction

    task automatic applyStimulus(input string name, input logic [5:0] op, input logic zero,
                                 input int fetch_stalls, input int mem_stalls);
        phase_t    phases[$];
        bit        readies[$];
        int        done_at;
        sb_entry_t e;
        sb_entry_t got;
        done_at = 0;
        for (int i = 0; i <= fetch_stalls; i++) begin
            phases.push_back(P_FETCH);
            readies.push_back(i == fetch_stalls);
        end
        phases.push_back(P_DECODE);
        readies.push_back(1'($urandom_range(0, 1)));
        case (op)
            6'h00: begin
                phases.push_back(P_R_EXEC); readies.push_back(1'($urandom_range(0, 1)));
                phases.push_back(P_R_WB);   readies.push_back(1'($urandom_range(0, 1)));
            end
            6'h08, 6'h0D, 6'h0C, 6'h0F: begin
                phases.push_back(P_I_EXEC); readies.push_back(1'($urandom_range(0, 1)));
                phases.push_back(P_I_WB);   readies.push_back(1'($urandom_range(0, 1)));
            end
            6'h23, 6'h2B: begin
                phases.push_back(P_MEM_ADDR); readies.push_back(1'($urandom_range(0, 1)));
                for (int i = 0; i <= mem_stalls; i++) begin
                    phases.push_back((op == 6'h23) ? P_MEM_READ : P_MEM_WRITE);
                    readies.push_back(i == mem_stalls);
                end
                if (op == 6'h23) begin
                    phases.push_back(P_MEM_WB); readies.push_back(1'($urandom_range(0, 1)));
                end
            end
            6'h04, 6'h05: begin
                phases.push_back(P_BRANCH); readies.push_back(1'($urandom_range(0, 1)));
            end
            6'h02: begin
                phases.push_back(P_JUMP); readies.push_back(1'($urandom_range(0, 1)));
            end
            default: ;
        endcase
        if (is_legal(op)) model_cnt = model_cnt + 4'd1;
        e.name   = name;
        e.cycles = phases.size();
        e.cnt    = model_cnt;
        scoreboard.push_back(e);

        foreach (phases[i]) begin
            @(negedge clk);
            bus.OP       = op;
            bus.Zero     = zero;
            bus.MemReady = readies[i];
            #1;
            checkOutput($sformatf("%s_c%0d", name, i), 32'(observed_outputs()),
                        32'(expect_outputs(phases[i], op, zero, readies[i])));
            if ((bus.InstrDone || bus.IllegalOp) && done_at == 0) done_at = i + 1;
        end
        @(posedge clk);
        #1;
        got = scoreboard.pop_front();
        checkOutput({got.name, "_cycles"}, 32'(done_at), 32'(got.cycles));
        checkOutput({got.name, "_cnt"}, 32'(bus.RetiredCnt), 32'(got.cnt));
    endtask

    task automatic resetMidLoad();
        phase_t phases[4];
        bit     readies[4];
        phases  = '{P_FETCH, P_DECODE, P_MEM_ADDR, P_MEM_READ};
        readies = '{1'b1, 1'b1, 1'b0, 1'b0};
        foreach (phases[i]) begin
            @(negedge clk);
            bus.OP       = 6'h23;
            bus.Zero     = 1'b0;
            bus.MemReady = readies[i];
            #1;
            checkOutput($sformatf("rstlw_c%0d", i), 32'(observed_outputs()),
                        32'(expect_outputs(phases[i], 6'h23, 1'b0, readies[i])));
        end
        reset = 1'b0;
        #1;
        checkOutput("rstlw_outputs", 32'(observed_outputs()), 32'd0);
        checkOutput("rstlw_cnt", 32'(bus.RetiredCnt), 32'd0);
        model_cnt = 4'd0;
        @(negedge clk);
        reset = 1'b1;
        #1;
        checkOutput("rstlw_idle", 32'(observed_outputs()), 32'd0);
    endtask

    instr_t program_table[14];

    initial begin
        program_table = '{
            '{"add",   6'h00, 1'b0, 0, 0},
            '{"addi",  6'h08, 1'b0, 0, 0},
            '{"ori",   6'h0D, 1'b1, 0, 0},
            '{"andi",  6'h0C, 1'b0, 1, 0},
            '{"lui",   6'h0F, 1'b0, 0, 0},
            '{"lw",    6'h23, 1'b0, 3, 2},
            '{"sw",    6'h2B, 1'b0, 0, 1},
            '{"beq_z", 6'h04, 1'b1, 0, 0},
            '{"bne_z", 6'h05, 1'b1, 0, 0},
            '{"beq_n", 6'h04, 1'b0, 0, 0},
            '{"bne_n", 6'h05, 1'b0, 2, 0},
            '{"ill3f", 6'h3F, 1'b0, 0, 0},
            '{"ill01", 6'h01, 1'b1, 1, 0},
            '{"j",     6'h02, 1'b0, 0, 0}
        };

        bus.OP              = 6'h00;
        bus.Zero            = 1'b0;
        bus.MemReady        = 1'b0;
        bus_nowait.OP       = 6'h02;
        bus_nowait.Zero     = 1'b0;
        bus_nowait.MemReady = 1'b0;

        @(negedge clk);
        #1;
        checkOutput("reset_outputs", 32'(observed_outputs()), 32'd0);
        checkOutput("reset_cnt", 32'(bus.RetiredCnt), 32'd0);
        reset = 1'b1;
        #1;
        checkOutput("idle_outputs", 32'(observed_outputs()), 32'd0);

        foreach (program_table[i]) begin
            applyStimulus(program_table[i].name, program_table[i].op, program_table[i].zero,
                          program_table[i].fetch_stalls, program_table[i].mem_stalls);
        end

        resetMidLoad();

        // Sixteen jumps take the 4-bit counter from 0 through 15 and back to 0
        for (int i = 0; i < 16; i++) begin
            applyStimulus($sformatf("jwrap%0d", i), 6'h02, 1'(i % 2), 0, 0);
        end

        @(negedge clk);
        reset        = 1'b0;
        bus.OP       = 6'h02;
        bus.MemReady = 1'b1;
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("nowait_fetch", 32'({bus_nowait.IRWrite, bus_nowait.PCWrite, bus_nowait.MemRead}),
                    32'(3'b111));
        repeat (15) @(posedge clk);
        #1;
        checkOutput("nowait_cnt", bus_nowait.RetiredCnt, 32'd5);
        checkOutput("jstream_cnt", 32'(bus.RetiredCnt), 32'd5);

        $display("Result: errors=%0d of %0d checks", num_errors, num_checks);
        $finish;
    end

endmodule
